// File: rtl/sevenseg_scan_driver_if.sv
// Bundles the display value strobe, live controls and the scanned anode/cathode outputs
// that connect an upstream value source to the seven-segment scan driver.
interface sevenseg_scan_driver_if;
  logic [31:0] value;
  logic        value_valid;
  logic        blank_lz;
  logic [7:0]  digit_en;
  logic [6:0]  seg;
  logic [7:0]  AN;
  logic        frame_done;

  modport master (
    output value, value_valid, blank_lz, digit_en,
    input  seg, AN, frame_done
  );

  modport slave (
    input  value, value_valid, blank_lz, digit_en,
    output seg, AN, frame_done
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// Eight-digit common-anode scan driver: one anode per slot with a dark guard interval,
// hex decode to active-low segments, and values swapped in only at frame boundaries.
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input logic CLK100MHZ,
  input logic rst,
  sevenseg_scan_driver_if.slave bus
);
  localparam int            PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  logic [PW-1:0] p_reg;
  logic [2:0]    digit_reg;
  logic [31:0]   shadow_reg;
  logic [31:0]   disp_reg;
  logic          pending_reg;
  logic [6:0]    seg_reg;
  logic [7:0]    an_reg;
  logic          frame_done_reg;

  logic          slot_end;
  logic          frame_end;
  logic [7:1]    upper_zero;
  logic [7:0]    blank;
  logic [3:0]    nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign slot_end  = (p_reg == P_LAST);
  assign frame_end = slot_end && (digit_reg == 3'd7);
  assign nibble    = disp_reg[{digit_reg, 2'b00} +: 4];

  // Digit 0 always shows something unless explicitly disabled, so a zero value reads "0".
  assign blank[0] = ~bus.digit_en[0];

  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_blank
      assign upper_zero[gi] = (disp_reg[31:4*gi] == '0);
      assign blank[gi]      = ~bus.digit_en[gi] | (bus.blank_lz & upper_zero[gi]);
    end
  endgenerate

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      p_reg          <= '0;
      digit_reg      <= 3'd0;
      shadow_reg     <= 32'd0;
      disp_reg       <= 32'd0;
      pending_reg    <= 1'b0;
      seg_reg        <= 7'h7F;
      an_reg         <= 8'hFF;
      frame_done_reg <= 1'b0;
    end else begin
      p_reg <= slot_end ? '0 : p_reg + P_ONE;
      if (slot_end) begin
        digit_reg <= digit_reg + 3'd1;
      end

      if (bus.value_valid) begin
        shadow_reg  <= bus.value;
        pending_reg <= 1'b1;
      end

      // A strobe landing on the boundary cycle bypasses the shadow so it is not a frame late.
      if (frame_end) begin
        if (bus.value_valid) begin
          disp_reg <= bus.value;
        end else if (pending_reg) begin
          disp_reg <= shadow_reg;
        end
        pending_reg <= 1'b0;
      end

      frame_done_reg <= frame_end;

      if ((p_reg < P_GUARD) || blank[digit_reg]) begin
        an_reg  <= 8'hFF;
        seg_reg <= 7'h7F;
      end else begin
        an_reg  <= ~(8'b1 << digit_reg);
        seg_reg <= hex_to_seg(nibble);
      end
    end
  end

  assign bus.seg        = seg_reg;
  assign bus.AN         = an_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Randomised bench for the scan driver: a cycle-indexed reference model queues the expected
// outputs each clock and an independent monitor pops and checks them on the falling edge.
module tb_sevenseg_scan_driver;
  localparam int R = 8;
  localparam int G = 2;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  logic CLK100MHZ = 1'b0;
  logic rst;
  sevenseg_scan_driver_if bus ();

  sevenseg_scan_driver #(.REFRESH_DIV(R), .GUARD(G)) dut (
    .CLK100MHZ (CLK100MHZ),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  exp_t        exp_q[$];
  int unsigned cyc;
  logic [31:0] latest;
  logic [31:0] disp_m;
  int          tests = 0;
  int          fails = 0;

  // Reference: cycle index since reset gives slot and digit directly; the shown value
  // for a frame is simply the most recent strobe at or before the preceding boundary.
  always @(posedge CLK100MHZ) begin
    exp_t        e;
    int          p;
    int          d;
    logic [31:0] upper;
    bit          boundary;
    if (rst) begin
      cyc    = 0;
      latest = 32'd0;
      disp_m = 32'd0;
      e      = '{an: 8'hFF, seg: 7'h7F, fd: 1'b0};
    end else begin
      p        = int'(cyc % R);
      d        = int'((cyc / R) % 8);
      upper    = disp_m >> (4 * d);
      boundary = (p == R - 1) && (d == 7);
      if (bus.value_valid) latest = bus.value;
      if (p < G || !bus.digit_en[d] || (bus.blank_lz && d != 0 && upper == 32'd0)) begin
        e.an  = 8'hFF;
        e.seg = 7'h7F;
      end else begin
        e.an  = ~(8'h01 << d);
        e.seg = SEG_TAB[upper[3:0]];
      end
      e.fd = boundary;
      if (boundary) disp_m = latest;
      cyc++;
    end
    exp_q.push_back(e);
  end

  always @(negedge CLK100MHZ) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (bus.AN !== e.an || bus.seg !== e.seg || bus.frame_done !== e.fd) begin
        fails++;
        $display("FAIL scan cyc=%0d: got AN=%h seg=%h fd=%b, want AN=%h seg=%h fd=%b",
                 cyc, bus.AN, bus.seg, bus.frame_done, e.an, e.seg, e.fd);
      end
      tests++;
      if ($countones(~bus.AN) > 1) begin
        fails++;
        $display("FAIL one_anode cyc=%0d: got AN=%h, want at most one low bit", cyc, bus.AN);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK100MHZ);
      #2;
    end
  endtask

  task automatic strobe(input logic [31:0] v);
    $display("[TB] strobe value=%h at cyc=%0d", v, cyc);
    bus.value       = v;
    bus.value_valid = 1'b1;
    step(1);
    bus.value_valid = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 64 && int'(cyc % 64) != ph; i++) step(1);
  endtask

  initial begin
    rst             = 1'b1;
    bus.value       = 32'd0;
    bus.value_valid = 1'b0;
    bus.blank_lz    = 1'b0;
    bus.digit_en    = 8'hFF;
    step(3);
    rst = 1'b0;
    $display("[TB] reset released, idle scan");
    step(133);

    wait_phase(20);
    strobe(32'h89AB_CDEF);
    step(130);

    bus.blank_lz = 1'b1;
    strobe(32'h0000_0120);
    step(130);
    strobe(32'h0000_0000);
    step(130);
    bus.blank_lz = 1'b0;

    wait_phase(10);
    strobe(32'h1111_1111);
    step($urandom_range(1, 20));
    strobe(32'h2222_2222);
    step(70);
    wait_phase(63);
    strobe($urandom);
    step(70);

    $display("[TB] digit_en=aa then live toggles");
    bus.digit_en = 8'hAA;
    step(64);
    repeat (12) begin
      step($urandom_range(1, 7));
      bus.digit_en = 8'($urandom);
    end
    bus.digit_en = 8'hFF;

    repeat (300) begin
      step($urandom_range(1, 12));
      case ($urandom_range(0, 3))
        0: strobe($urandom >> $urandom_range(0, 31));
        1: bus.blank_lz = ~bus.blank_lz;
        2: bus.digit_en = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
        default: strobe($urandom);
      endcase
    end
    bus.blank_lz = 1'b0;
    bus.digit_en = 8'hFF;

    wait_phase(30);
    strobe(32'h7654_3210);
    step(70);
    wait_phase(20);
    strobe(32'hFEDC_BA98);
    wait_phase(44);
    $display("[TB] reset pulse mid-slot at cyc=%0d", cyc);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(140);

    step(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
